// File: rtl/cpu_types_pkg.sv
// Shared types for the MIPS pipeline: register tags, hazard modes and tag helpers.
package cpu_types_pkg;

  localparam int REG_W = 5;

  typedef logic [REG_W-1:0] regbits_t;

  typedef struct packed {
    logic     valid;
    regbits_t wsel;
    logic     memread;
  } hz_tag_t;

  typedef enum logic [2:0] {
    HZ_RUN,
    HZ_MISS,
    HZ_LOADUSE,
    HZ_FLUSH,
    HZ_FREEZE
  } hz_mode_t;

  // A write to $0 is architecturally discarded, so it never yields a live tag.
  function automatic hz_tag_t make_tag(input logic regwr, input regbits_t wsel,
                                       input logic memread);
    hz_tag_t t;
    t.valid   = regwr && (wsel != '0);
    t.wsel    = wsel;
    t.memread = memread;
    return t;
  endfunction

  function automatic regbits_t tag_dest(input regbits_t wsel, input logic valid);
    return valid ? wsel : '0;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Bundle of hazard controller signals, with one view for the controller and one for its driver.
interface hazard_scoreboard_if
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic CLK
);
  logic             RST;
  logic             ihit;
  logic             dmem_req;
  logic             dhit;
  regbits_t         id_rs;
  regbits_t         id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             id_regwr;
  regbits_t         id_wsel;
  logic             id_memread;
  logic             ex_branch_taken;
  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_flush;
  regbits_t         reg_wr_ex;
  regbits_t         reg_wr_mem;
  regbits_t         reg_wr_wb;
  logic             load_use_stall;
  logic [CNT_W-1:0] lu_count;
  logic [CNT_W-1:0] flush_count;

  modport hs (
    input  CLK, RST, ihit, dmem_req, dhit, id_rs, id_rt, id_uses_rs, id_uses_rt,
           id_regwr, id_wsel, id_memread, ex_branch_taken,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
           reg_wr_ex, reg_wr_mem, reg_wr_wb, load_use_stall, lu_count, flush_count
  );

  modport tb (
    input  CLK, pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
           reg_wr_ex, reg_wr_mem, reg_wr_wb, load_use_stall, lu_count, flush_count,
    output RST, ihit, dmem_req, dhit, id_rs, id_rt, id_uses_rs, id_uses_rt,
           id_regwr, id_wsel, id_memread, ex_branch_taken
  );
endinterface

// File: rtl/hz_tag_stage.sv
// One destination-tag register for a pipeline stage; clear wins over load.
module hz_tag_stage
  import cpu_types_pkg::*;
(
  input  logic    CLK,
  input  logic    en,
  input  logic    clr,
  input  hz_tag_t d,
  output hz_tag_t q
);

  always_ff @(posedge CLK) begin
    if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard controller: tracks EX/MEM/WB destination tags, decodes stall/flush/freeze modes, counts events.
module hazard_scoreboard
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dmem_req,
  input  logic             dhit,
  input  regbits_t         id_rs,
  input  regbits_t         id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_regwr,
  input  regbits_t         id_wsel,
  input  logic             id_memread,
  input  logic             ex_branch_taken,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output regbits_t         reg_wr_ex,
  output regbits_t         reg_wr_mem,
  output regbits_t         reg_wr_wb,
  output logic             load_use_stall,
  output logic [CNT_W-1:0] lu_count,
  output logic [CNT_W-1:0] flush_count
);

  hz_tag_t  ex_tag;
  hz_tag_t  mem_tag;
  hz_tag_t  wb_tag;
  hz_tag_t  id_tag;
  hz_mode_t mode;
  logic     mem_wait;
  logic     lu_hit;
  logic     advance;
  logic     ex_kill;
  logic     unused_memread;

  assign id_tag   = make_tag(id_regwr, id_wsel, id_memread);
  assign mem_wait = dmem_req & ~dhit;
  assign lu_hit   = ex_tag.valid & ex_tag.memread &
                    ((id_uses_rs & (id_rs == ex_tag.wsel)) |
                     (id_uses_rt & (id_rt == ex_tag.wsel)));

  // Mode priority: a pending data access freezes everything, so a held branch
  // is acted on only once memory completes; a taken branch squashes the consumer
  // of any load-use hit seen in the same cycle.
  always_comb begin
    mode = HZ_RUN;
    if (mem_wait) begin
      mode = HZ_FREEZE;
    end else if (ex_branch_taken) begin
      mode = HZ_FLUSH;
    end else if (lu_hit) begin
      mode = HZ_LOADUSE;
    end else if (!ihit) begin
      mode = HZ_MISS;
    end
  end

  always_comb begin
    pc_en          = 1'b0;
    ifid_en        = 1'b0;
    idex_en        = 1'b0;
    exmem_en       = 1'b0;
    memwb_en       = 1'b0;
    ifid_flush     = 1'b0;
    idex_flush     = 1'b0;
    load_use_stall = 1'b0;
    if (!RST) begin
      case (mode)
        HZ_FREEZE: ;
        HZ_FLUSH: begin
          pc_en      = 1'b1;
          ifid_en    = 1'b1;
          idex_en    = 1'b1;
          exmem_en   = 1'b1;
          memwb_en   = 1'b1;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end
        HZ_LOADUSE: begin
          idex_en        = 1'b1;
          exmem_en       = 1'b1;
          memwb_en       = 1'b1;
          idex_flush     = 1'b1;
          load_use_stall = 1'b1;
        end
        HZ_MISS: begin
          ifid_en    = 1'b1;
          idex_en    = 1'b1;
          exmem_en   = 1'b1;
          memwb_en   = 1'b1;
          ifid_flush = 1'b1;
        end
        default: begin
          pc_en    = 1'b1;
          ifid_en  = 1'b1;
          idex_en  = 1'b1;
          exmem_en = 1'b1;
          memwb_en = 1'b1;
        end
      endcase
    end
  end

  assign advance = ~RST & (mode != HZ_FREEZE);
  assign ex_kill = (mode == HZ_FLUSH) | (mode == HZ_LOADUSE);

  // Tag pipeline: ID -> EX -> MEM -> WB; EX takes a bubble on flush or load-use.
  hz_tag_stage u_ex (
    .CLK (CLK),
    .en  (advance),
    .clr (RST | (advance & ex_kill)),
    .d   (id_tag),
    .q   (ex_tag)
  );

  hz_tag_stage u_mem (
    .CLK (CLK),
    .en  (advance),
    .clr (RST),
    .d   (ex_tag),
    .q   (mem_tag)
  );

  hz_tag_stage u_wb (
    .CLK (CLK),
    .en  (advance),
    .clr (RST),
    .d   (mem_tag),
    .q   (wb_tag)
  );

  assign reg_wr_ex      = tag_dest(ex_tag.wsel, ex_tag.valid);
  assign reg_wr_mem     = tag_dest(mem_tag.wsel, mem_tag.valid);
  assign reg_wr_wb      = tag_dest(wb_tag.wsel, wb_tag.valid);
  assign unused_memread = mem_tag.memread ^ wb_tag.memread;

  always_ff @(posedge CLK) begin
    if (RST) begin
      lu_count    <= '0;
      flush_count <= '0;
    end else begin
      if (mode == HZ_FLUSH) begin
        flush_count <= flush_count + CNT_W'(1);
      end
      if (mode == HZ_LOADUSE) begin
        lu_count <= lu_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: expectations queued with each stimulus cycle, drained against the DUT.
module tb_hazard_scoreboard;
  import cpu_types_pkg::*;

  localparam int CNT_W = 16;

  localparam int S_EN  = 0;  // {pc,ifid,idex,exmem,memwb}
  localparam int S_FL  = 1;  // {ifid_flush,idex_flush}
  localparam int S_EX  = 2;
  localparam int S_MEM = 3;
  localparam int S_WB  = 4;
  localparam int S_LUS = 5;
  localparam int S_LUC = 6;
  localparam int S_FLC = 7;

  typedef struct {
    string tag;
    int    sel;
    int    exp;
  } exp_t;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  hazard_scoreboard_if #(.CNT_W(CNT_W)) hif (.CLK(CLK));

  hazard_scoreboard #(.CNT_W(CNT_W)) dut (
    .CLK             (CLK),
    .RST             (hif.RST),
    .ihit            (hif.ihit),
    .dmem_req        (hif.dmem_req),
    .dhit            (hif.dhit),
    .id_rs           (hif.id_rs),
    .id_rt           (hif.id_rt),
    .id_uses_rs      (hif.id_uses_rs),
    .id_uses_rt      (hif.id_uses_rt),
    .id_regwr        (hif.id_regwr),
    .id_wsel         (hif.id_wsel),
    .id_memread      (hif.id_memread),
    .ex_branch_taken (hif.ex_branch_taken),
    .pc_en           (hif.pc_en),
    .ifid_en         (hif.ifid_en),
    .idex_en         (hif.idex_en),
    .exmem_en        (hif.exmem_en),
    .memwb_en        (hif.memwb_en),
    .ifid_flush      (hif.ifid_flush),
    .idex_flush      (hif.idex_flush),
    .reg_wr_ex       (hif.reg_wr_ex),
    .reg_wr_mem      (hif.reg_wr_mem),
    .reg_wr_wb       (hif.reg_wr_wb),
    .load_use_stall  (hif.load_use_stall),
    .lu_count        (hif.lu_count),
    .flush_count     (hif.flush_count)
  );

  int   errors = 0;
  int   checks = 0;
  exp_t sbq[$];

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int get(input int sel);
    case (sel)
      S_EN:    return int'({hif.pc_en, hif.ifid_en, hif.idex_en, hif.exmem_en, hif.memwb_en});
      S_FL:    return int'({hif.ifid_flush, hif.idex_flush});
      S_EX:    return int'(hif.reg_wr_ex);
      S_MEM:   return int'(hif.reg_wr_mem);
      S_WB:    return int'(hif.reg_wr_wb);
      S_LUS:   return int'(hif.load_use_stall);
      S_LUC:   return int'(hif.lu_count);
      S_FLC:   return int'(hif.flush_count);
      default: return -1;
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input int exp);
    sbq.push_back('{tag, sel, exp});
  endtask

  task automatic drain();
    while (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk(e.tag, get(e.sel), e.exp);
    end
  endtask

  // Inputs settle, queued expectations are compared, then one clock edge passes.
  task automatic cyc();
    #1;
    drain();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic idle();
    hif.RST             = 1'b0;
    hif.ihit            = 1'b1;
    hif.dmem_req        = 1'b0;
    hif.dhit            = 1'b0;
    hif.id_rs           = '0;
    hif.id_rt           = '0;
    hif.id_uses_rs      = 1'b0;
    hif.id_uses_rt      = 1'b0;
    hif.id_regwr        = 1'b0;
    hif.id_wsel         = '0;
    hif.id_memread      = 1'b0;
    hif.ex_branch_taken = 1'b0;
  endtask

  task automatic rand_in();
    hif.ihit            = 1'($urandom_range(0, 1));
    hif.dmem_req        = 1'($urandom_range(0, 1));
    hif.dhit            = 1'($urandom_range(0, 1));
    hif.id_rs           = regbits_t'($urandom);
    hif.id_rt           = regbits_t'($urandom);
    hif.id_uses_rs      = 1'($urandom_range(0, 1));
    hif.id_uses_rt      = 1'($urandom_range(0, 1));
    hif.id_regwr        = 1'($urandom_range(0, 1));
    hif.id_wsel         = regbits_t'($urandom);
    hif.id_memread      = 1'($urandom_range(0, 1));
    hif.ex_branch_taken = 1'($urandom_range(0, 1));
  endtask

  task automatic issue(input int wsel, input logic load);
    hif.id_regwr   = 1'b1;
    hif.id_wsel    = regbits_t'(wsel);
    hif.id_memread = load;
  endtask

  initial begin
    @(negedge CLK);
    // Reset held for two cycles with random inputs
    hif.RST = 1'b1;
    rand_in();
    push("rst_en0", S_EN, 0);
    push("rst_fl0", S_FL, 0);
    push("rst_lus0", S_LUS, 0);
    cyc();
    hif.RST = 1'b1;
    rand_in();
    push("rst_en1", S_EN, 0);
    push("rst_ex", S_EX, 0);
    push("rst_mem", S_MEM, 0);
    push("rst_wb", S_WB, 0);
    push("rst_luc", S_LUC, 0);
    push("rst_flc", S_FLC, 0);
    cyc();

    // First cycle after release
    idle();
    push("rel_en", S_EN, 31);
    push("rel_fl", S_FL, 0);
    push("rel_ex", S_EX, 0);
    push("rel_wb", S_WB, 0);
    cyc();

    // Tag shift of $8 through EX, MEM, WB
    idle();
    issue(8, 1'b0);
    cyc();
    idle();
    push("sh_ex", S_EX, 8);
    push("sh_mem0", S_MEM, 0);
    cyc();
    idle();
    push("sh_mem", S_MEM, 8);
    push("sh_ex0", S_EX, 0);
    cyc();
    idle();
    push("sh_wb", S_WB, 8);
    push("sh_mem1", S_MEM, 0);
    cyc();
    idle();
    push("sh_wb0", S_WB, 0);
    cyc();

    // Load to $0 creates no tag and no stall
    idle();
    issue(0, 1'b1);
    cyc();
    idle();
    hif.id_uses_rs = 1'b1;
    hif.id_rs      = '0;
    push("z_ex", S_EX, 0);
    push("z_lus", S_LUS, 0);
    push("z_en", S_EN, 31);
    cyc();

    // Load-use: lw $9 then add reading $9
    idle();
    issue(9, 1'b1);
    cyc();
    idle();
    hif.id_uses_rs = 1'b1;
    hif.id_rs      = 5'd9;
    issue(10, 1'b0);
    push("lu_ex", S_EX, 9);
    push("lu_lus", S_LUS, 1);
    push("lu_en", S_EN, 7);
    push("lu_fl", S_FL, 1);
    push("lu_luc0", S_LUC, 0);
    cyc();
    push("lu2_lus", S_LUS, 0);
    push("lu2_en", S_EN, 31);
    push("lu2_fl", S_FL, 0);
    push("lu2_ex", S_EX, 0);
    push("lu2_mem", S_MEM, 9);
    push("lu2_luc", S_LUC, 1);
    cyc();
    idle();
    push("lu3_ex", S_EX, 10);
    push("lu3_wb", S_WB, 9);
    push("lu3_mem", S_MEM, 0);
    cyc();

    // Taken branch in the same cycle as a load-use hit
    idle();
    issue(11, 1'b1);
    cyc();
    idle();
    hif.id_uses_rt      = 1'b1;
    hif.id_rt           = 5'd11;
    hif.ex_branch_taken = 1'b1;
    push("br_lus", S_LUS, 0);
    push("br_fl", S_FL, 3);
    push("br_en", S_EN, 31);
    push("br_ex", S_EX, 11);
    push("br_flc0", S_FLC, 0);
    cyc();
    idle();
    push("br_flc", S_FLC, 1);
    push("br_luc", S_LUC, 1);
    push("br_ex0", S_EX, 0);
    push("br_mem", S_MEM, 11);
    cyc();

    // Freeze for 4 cycles with a held taken branch
    idle();
    issue(12, 1'b0);
    cyc();
    idle();
    issue(13, 1'b0);
    cyc();
    for (int i = 0; i < 4; i++) begin
      idle();
      issue(14, 1'b0);
      hif.dmem_req        = 1'b1;
      hif.dhit            = 1'b0;
      hif.ex_branch_taken = 1'b1;
      push("fz_en", S_EN, 0);
      push("fz_fl", S_FL, 0);
      push("fz_ex", S_EX, 13);
      push("fz_mem", S_MEM, 12);
      push("fz_wb", S_WB, 0);
      push("fz_flc", S_FLC, 1);
      cyc();
    end
    idle();
    issue(14, 1'b0);
    hif.dmem_req        = 1'b1;
    hif.dhit            = 1'b1;
    hif.ex_branch_taken = 1'b1;
    push("fzr_en", S_EN, 31);
    push("fzr_fl", S_FL, 3);
    cyc();
    idle();
    push("fzr_flc", S_FLC, 2);
    push("fzr_ex", S_EX, 0);
    push("fzr_mem", S_MEM, 13);
    push("fzr_wb", S_WB, 12);
    cyc();

    // Instruction miss bubbles IF/ID, back end advances
    idle();
    hif.ihit = 1'b0;
    issue(15, 1'b0);
    push("ms_en", S_EN, 15);
    push("ms_fl", S_FL, 2);
    cyc();
    idle();
    push("ms_ex", S_EX, 15);
    cyc();

    // Reset asserted mid-freeze clears everything
    idle();
    hif.RST      = 1'b1;
    hif.dmem_req = 1'b1;
    hif.dhit     = 1'b0;
    push("rf_en", S_EN, 0);
    push("rf_mem", S_MEM, 15);
    cyc();
    idle();
    push("rf_ex", S_EX, 0);
    push("rf_mem0", S_MEM, 0);
    push("rf_wb", S_WB, 0);
    push("rf_flc", S_FLC, 0);
    push("rf_luc", S_LUC, 0);
    push("rf_en1", S_EN, 31);
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
